// File: rtl/key_led_latch.sv
// key_led_latch: per-channel key synchroniser and debouncer with one-cycle
// press pulses, driving LEDs in follow, toggle or set-latch mode.
// Pipeline: key_p0/key_p1 synchroniser -> stable_p2 debounced level ->
// press_o / led_o registered outputs.
module key_led_latch #(
    parameter int N_KEYS          = 4,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter bit KEY_ACTIVE_LOW  = 1'b1
) (
    input  logic              clk50m_i,
    input  logic              rst_n_i,
    input  logic [N_KEYS-1:0] key_i,
    input  logic [1:0]        mode_i,
    input  logic              clear_i,
    output logic [N_KEYS-1:0] press_o,
    output logic [N_KEYS-1:0] led_o
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [N_KEYS-1:0] RELEASED_RAW = {N_KEYS{KEY_ACTIVE_LOW}};

    typedef enum logic [1:0] {
        MODE_FOLLOW     = 2'd0,
        MODE_TOGGLE     = 2'd1,
        MODE_SET        = 2'd2,
        MODE_FOLLOW_ALT = 2'd3
    } mode_e;

    logic [N_KEYS-1:0] key_p0;
    logic [N_KEYS-1:0] key_p1;
    logic [N_KEYS-1:0] pressed_p1;
    logic [N_KEYS-1:0] stable_p2;
    logic [CNT_W-1:0]  cnt_p2 [N_KEYS];
    logic [N_KEYS-1:0] stable_d_p3;
    logic [N_KEYS-1:0] press_edge_p3;
    logic [1:0]        mode_q;

    // Next LED state once the mode has been steady for at least one cycle.
    function automatic logic [N_KEYS-1:0] led_next(
        input logic [1:0]        mode,
        input logic [N_KEYS-1:0] led_cur,
        input logic [N_KEYS-1:0] stable,
        input logic [N_KEYS-1:0] press,
        input logic              clear
    );
        logic [N_KEYS-1:0] nxt;
        nxt = stable;
        case (mode_e'(mode))
            MODE_TOGGLE: nxt = clear ? '0 : (led_cur ^ press);
            MODE_SET:    nxt = clear ? '0 : (led_cur | press);
            default:     nxt = stable;
        endcase
        return nxt;
    endfunction

    // ---- stage p0/p1: two-flop synchroniser, reset to the released level
    always_ff @(posedge clk50m_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            key_p0 <= RELEASED_RAW;
            key_p1 <= RELEASED_RAW;
        end else begin
            key_p0 <= key_i;
            key_p1 <= key_p0;
        end
    end

    // Normalise polarity so that 1 always means pressed.
    assign pressed_p1 = key_p1 ^ RELEASED_RAW;

    // ---- stage p2: debounce; a level must persist DEBOUNCE_CYCLES samples
    always_ff @(posedge clk50m_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            stable_p2 <= '0;
            for (int i = 0; i < N_KEYS; i++) begin
                cnt_p2[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_KEYS; i++) begin
                if (pressed_p1[i] == stable_p2[i]) begin
                    cnt_p2[i] <= '0;
                end else if (cnt_p2[i] != CNT_LAST) begin
                    cnt_p2[i] <= cnt_p2[i] + CNT_W'(1);
                end else begin
                    stable_p2[i] <= pressed_p1[i];
                    cnt_p2[i]    <= '0;
                end
            end
        end
    end

    // Rising edge of the debounced level; releases never produce a pulse.
    assign press_edge_p3 = stable_p2 & ~stable_d_p3;

    // ---- stage p3: registered press pulse and edge-detect history
    always_ff @(posedge clk50m_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            stable_d_p3 <= '0;
            press_o     <= '0;
        end else begin
            stable_d_p3 <= stable_p2;
            press_o     <= press_edge_p3;
        end
    end

    // ---- stage p3: LED register; a mode change blanks the LEDs for one cycle
    always_ff @(posedge clk50m_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            mode_q <= 2'd0;
            led_o  <= '0;
        end else begin
            mode_q <= mode_i;
            if (mode_i != mode_q) begin
                led_o <= '0;
            end else begin
                led_o <= led_next(mode_i, led_o, stable_p2, press_edge_p3, clear_i);
            end
        end
    end

endmodule

// File: tb/tb_key_led_latch.sv
// Testbench for key_led_latch with DEBOUNCE_CYCLES=4, active-low keys.
// Each driven cycle pushes its expected outputs to a scoreboard; a negedge
// monitor pops and compares them once the corresponding clock edge has run.
module tb_key_led_latch;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] key;
    logic [1:0] mode;
    logic       clear;
    logic [3:0] press;
    logic [3:0] led;

    int cyc    = 0;
    int checks = 0;
    int errs   = 0;

    typedef struct {
        int         due;
        logic [3:0] press;
        logic [3:0] led;
        string      name;
    } exp_t;

    typedef struct {
        logic [3:0] key;
        logic [1:0] mode;
        logic       clear;
        logic [3:0] press;
        logic [3:0] led;
        string      name;
    } vec_t;

    exp_t sb[$];
    vec_t tbl[$];

    key_led_latch #(
        .N_KEYS         (4),
        .DEBOUNCE_CYCLES(4),
        .KEY_ACTIVE_LOW (1'b1)
    ) dut (
        .clk50m_i(clk),
        .rst_n_i (rst_n),
        .key_i   (key),
        .mode_i  (mode),
        .clear_i (clear),
        .press_o (press),
        .led_o   (led)
    );

    always #10 clk = ~clk;

    // Edge counter used to time-stamp scoreboard entries.
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard monitor: compare the entry due at this edge.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            if (sb[0].due == cyc) begin
                checks++;
                if (press !== sb[0].press || led !== sb[0].led) begin
                    errs++;
                    $display("FAIL %s @edge%0d: press=%b led=%b, required press=%b led=%b",
                             sb[0].name, cyc, press, led, sb[0].press, sb[0].led);
                end
                void'(sb.pop_front());
            end else if (sb[0].due < cyc) begin
                checks++;
                errs++;
                $display("FAIL %s: expectation for edge %0d never compared", sb[0].name, sb[0].due);
                void'(sb.pop_front());
            end
        end
    end

    function automatic void add_rows(input int n, input logic [3:0] k, input logic [1:0] m,
                                     input logic c, input logic [3:0] p, input logic [3:0] l,
                                     input string nm);
        vec_t v;
        v.key = k; v.mode = m; v.clear = c; v.press = p; v.led = l; v.name = nm;
        for (int i = 0; i < n; i++) tbl.push_back(v);
    endfunction

    // Drive one cycle of inputs and queue what the outputs must be after the next edge.
    task automatic step(input logic [3:0] k, input logic [1:0] m, input logic c,
                        input logic [3:0] ep, input logic [3:0] el, input string nm);
        exp_t e;
        key   = k;
        mode  = m;
        clear = c;
        e.due   = cyc + 1;
        e.press = ep;
        e.led   = el;
        e.name  = nm;
        sb.push_back(e);
        @(negedge clk);
        #1;
    endtask

    task automatic check_now(input string nm, input logic [3:0] ep, input logic [3:0] el);
        checks++;
        if (press !== ep || led !== el) begin
            errs++;
            $display("FAIL %s: press=%b led=%b, required press=%b led=%b", nm, press, led, ep, el);
        end
    endtask

    // One full press (8 cycles held) and release (8 cycles) of the keys in mask m.
    // The pulse lands on step 6; mode switches from mb to ma and clear (clr6) apply there.
    task automatic press_cycle(input logic [3:0] m, input logic [1:0] mb, input logic [1:0] ma,
                               input logic clr6, input logic [3:0] prev, input logic [3:0] nxt,
                               input string nm);
        logic [3:0] k;
        logic [1:0] md;
        logic       c;
        logic [3:0] ep;
        logic [3:0] el;
        for (int s = 0; s < 16; s++) begin
            k  = (s < 8) ? ~m : 4'b1111;
            md = (s < 6) ? mb : ma;
            c  = (s == 6) ? clr6 : 1'b0;
            ep = (s == 6) ? m : 4'b0000;
            el = (s < 6) ? prev : nxt;
            step(k, md, c, ep, el, nm);
        end
    endtask

    initial begin
        // Scenario 1: reset held with all keys pressed, then release; FOLLOW mode.
        add_rows(6, 4'b0000, 2'd0, 1'b0, 4'b0000, 4'b0000, "rst_pressed_wait");
        add_rows(1, 4'b0000, 2'd0, 1'b0, 4'b1111, 4'b1111, "rst_pressed_pulse");
        add_rows(1, 4'b0000, 2'd0, 1'b0, 4'b0000, 4'b1111, "rst_pressed_hold");
        add_rows(6, 4'b1111, 2'd0, 1'b0, 4'b0000, 4'b1111, "follow_release_wait");
        add_rows(2, 4'b1111, 2'd0, 1'b0, 4'b0000, 4'b0000, "follow_released");
        // Scenario 2: 3-cycle glitch ignored, then a genuine press on key 0.
        add_rows(3, 4'b1110, 2'd0, 1'b0, 4'b0000, 4'b0000, "glitch_low");
        add_rows(4, 4'b1111, 2'd0, 1'b0, 4'b0000, 4'b0000, "glitch_after");
        add_rows(6, 4'b1110, 2'd0, 1'b0, 4'b0000, 4'b0000, "key0_wait");
        add_rows(1, 4'b1110, 2'd0, 1'b0, 4'b0001, 4'b0001, "key0_pulse");
        add_rows(1, 4'b1110, 2'd0, 1'b0, 4'b0000, 4'b0001, "key0_hold");
        add_rows(6, 4'b1111, 2'd0, 1'b0, 4'b0000, 4'b0001, "key0_release_wait");
        add_rows(2, 4'b1111, 2'd0, 1'b0, 4'b0000, 4'b0000, "key0_released");

        rst_n = 1'b1;
        key   = 4'b0000;
        mode  = 2'd0;
        clear = 1'b0;
        #2 rst_n = 1'b0;
        #1 check_now("reset_async_initial", 4'b0000, 4'b0000);
        @(negedge clk);
        #1;
        step(4'b0000, 2'd0, 1'b0, 4'b0000, 4'b0000, "in_reset_0");
        step(4'b0000, 2'd0, 1'b0, 4'b0000, 4'b0000, "in_reset_1");
        rst_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].key, tbl[i].mode, tbl[i].clear, tbl[i].press, tbl[i].led, tbl[i].name);
        end

        // Scenario 3: TOGGLE, three presses on key 2 -> 1,0,1.
        step(4'b1111, 2'd1, 1'b0, 4'b0000, 4'b0000, "to_toggle");
        press_cycle(4'b0100, 2'd1, 2'd1, 1'b0, 4'b0000, 4'b0100, "toggle_1");
        press_cycle(4'b0100, 2'd1, 2'd1, 1'b0, 4'b0100, 4'b0000, "toggle_2");
        press_cycle(4'b0100, 2'd1, 2'd1, 1'b0, 4'b0000, 4'b0100, "toggle_3");

        // Scenario 4: SET with keys 1 and 3 together, then clear beats key 0's press.
        step(4'b1111, 2'd2, 1'b0, 4'b0000, 4'b0000, "to_set");
        press_cycle(4'b1010, 2'd2, 2'd2, 1'b0, 4'b0000, 4'b1010, "set_k1k3");
        press_cycle(4'b0001, 2'd2, 2'd2, 1'b1, 4'b1010, 4'b0000, "set_clear_wins");

        // Scenario 5: build 0110 in SET, switch to TOGGLE on a press cycle.
        press_cycle(4'b0110, 2'd2, 2'd2, 1'b0, 4'b0000, 4'b0110, "set_k1k2");
        press_cycle(4'b0001, 2'd2, 2'd1, 1'b0, 4'b0110, 4'b0000, "mode_change_press");

        // Scenario 6: async reset while key 2 is mid-debounce (counter at 2).
        press_cycle(4'b1000, 2'd1, 2'd1, 1'b0, 4'b0000, 4'b1000, "toggle_k3");
        for (int i = 0; i < 4; i++) step(4'b1011, 2'd1, 1'b0, 4'b0000, 4'b1000, "pre_reset_hold");
        rst_n = 1'b0;
        #1 check_now("reset_async_mid", 4'b0000, 4'b0000);
        @(negedge clk);
        #1;
        step(4'b1011, 2'd1, 1'b0, 4'b0000, 4'b0000, "mid_reset_0");
        step(4'b1011, 2'd1, 1'b0, 4'b0000, 4'b0000, "mid_reset_1");
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) step(4'b1011, 2'd1, 1'b0, 4'b0000, 4'b0000, "post_reset_wait");
        step(4'b1011, 2'd1, 1'b0, 4'b0100, 4'b0100, "post_reset_pulse");
        step(4'b1011, 2'd1, 1'b0, 4'b0000, 4'b0100, "post_reset_hold");
        for (int i = 0; i < 8; i++) step(4'b1111, 2'd1, 1'b0, 4'b0000, 4'b0100, "post_reset_release");

        for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
        if (sb.size() > 0) begin
            checks++;
            errs++;
            $display("FAIL drain: %0d expectations left uncompared", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
